multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core variant. It sequences one shared ALU, one unified instruction/data memory port and the immediate generator across several cycles per instruction.
- Inputs are opcode/funct fields from the instruction register plus the ALU zero flag. Outputs are all datapath enables and selects, including the 3-bit immediate-type select for the immediate generator.
- Sits between the instruction register and the datapath muxes. It replaces the single-cycle combinational control.

Parameters:
- RESET_PC_WRITE, 0, value of pc_write while reset is high (kept 0; exists for bench override only).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7b5  in  1  instruction bit 30
- zero  in  1  ALU result == 0
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse in the last state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- Reset (already decided): one clock, clk; reset synchronous, active-high.
  - While reset is high, all enables are 0: pc_write, mem_write, ir_write, reg_write, retire, illegal_op.
  - All selects are 0 while reset is high.
  - State becomes FETCH on the first rising edge with reset high.
  - Reset asserted mid-instruction aborts it; no partial writes occur after that edge.
- Outputs are Moore, decoded from state. Exceptions:
  - pc_write in BRANCH depends on zero.
  - imm_src is decoded from op in every state.
  - alu_control is decoded from the alu_op class plus funct fields.
- imm_src by op:
  - 0000011 (lw), 0010011 (I-ALU): 000
  - 0100011 (sw): 001
  - 1100011 (branch): 010
  - 0110111 (lui): 011
  - 1101111 (jal): 100
  - others: 000
- States and transitions (all unlisted outputs are 0):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_write=1 -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next state by op:
    - lw/sw -> MEMADR
    - R -> EXEC_R
    - I-ALU -> EXEC_I
    - branch -> BRANCH
    - jal -> JAL
    - lui -> LUI_WB
    - other -> FETCH, with illegal_op=1
  - MEMADR: alu_src_a=10, alu_src_b=01, add -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00 -> MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, retire=1 -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, retire=1 -> FETCH.
  - EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=funct -> ALU_WB.
  - EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=funct -> ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, retire=1 -> FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, retire=1 -> FETCH.
    - pc_write = zero XOR funct3[0] (beq/bne).
    - funct3 other than 000/001: pc_write=0.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 -> ALU_WB. The ALUOut target goes to PC and PC+4 goes to rd.
  - LUI_WB: result_src=11, reg_write=1, retire=1 -> FETCH.
- Latency in cycles:
  - lw 5, sw 4, R 4, I-ALU 4, branch 3, jal 4, lui 3, illegal 2.
- ALU decode (alu_op class):
  - add class -> 000; sub class -> 001.
  - funct class, by funct3:
    - 000: sub (001) if op[5] & funct7b5 (R-type only), else add (000)
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - others -> 000
- Unreachable state encoding -> FETCH next cycle, all outputs 0.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL, OP_LUI)
  - imm_src, alu_control, alu_op, result_src and src_a/src_b encodings
- One combinational sub-module, alu_decoder, inputs alu_op, funct3, op[5], funct7b5 and output alu_control.
- FSM, imm_src decode and output decode stay in multicycle_control.

Test Plan:
- Reset held 3 cycles mid-MEMREAD -> all enables 0 during reset; first post-reset cycle in FETCH with ir_write=1, pc_write=1.
- op=0000011 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEM_WB; imm_src=000; reg_write=1 and retire=1 only in cycle 5.
- op=0100011 -> mem_write=1, adr_src=1 in cycle 4 only; imm_src=001; reg_write never 1.
- op=1100011, funct3=000:
  - zero=1 -> pc_write=1 in cycle 3.
  - zero=0 -> pc_write=0.
  - funct3=001 inverts both results.
- op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXEC_R. op=0010011, same funct -> alu_control=000, imm_src=000.
- op=1101111 -> imm_src=100, pc_write=1 in JAL, reg_write in cycle 4.
  - op=0110111 -> imm_src=011, result_src=11 and reg_write=1 in cycle 3.
  - op=1111111 -> illegal_op pulse in DECODE, back in FETCH next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation classes and datapath mux/select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StLuiWb
    } state_e;

    // Major opcodes handled by this core variant.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operation class chosen by the FSM; the funct class defers to funct3/funct7.
    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction funct fields onto the
// ALU control code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Decode ALU control from class and funct fields.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            AluOpAdd: alu_control = ALU_ADD;
            AluOpSub: alu_control = ALU_SUB;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type (op[5]=1) can request sub; addi ignores bit 30.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU,
// unified memory port and immediate generator over several cycles.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    alu_op_e    alu_op;
    logic [2:0] alu_control_dec;
    logic [2:0] imm_src_dec;
    logic       state_valid;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control_dec)
    );

    // State register; synchronous reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate type follows the opcode in every state.
    always_comb begin
        imm_src_dec = IMM_I;
        case (op)
            OP_LOAD, OP_IMM: imm_src_dec = IMM_I;
            OP_STORE:        imm_src_dec = IMM_S;
            OP_BRANCH:       imm_src_dec = IMM_B;
            OP_LUI:          imm_src_dec = IMM_U;
            OP_JAL:          imm_src_dec = IMM_J;
            default:         imm_src_dec = IMM_I;
        endcase
    end

    // Next-state and Moore output decode; reset and stray encodings force all outputs to 0.
    always_comb begin
        state_d     = StFetch;
        state_valid = 1'b1;
        alu_op      = AluOpAdd;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        reg_write   = 1'b0;
        retire      = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            StFetch: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                state_d    = StDecode;
            end
            StDecode: begin
                // Precompute OldPC + imm so a taken branch/jal finds its target in ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecR;
                    OP_IMM:            state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    OP_LUI:            state_d = StLuiWb;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                state_d    = StMemWb;
            end
            StMemWb: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = AluOpSub;
                result_src = RES_ALUOUT;
                retire     = 1'b1;
                // Only beq/bne are supported; funct3[0] selects the inverted sense.
                pc_write   = (funct3[2:1] == 2'b00) ? (zero ^ funct3[0]) : 1'b0;
                state_d    = StFetch;
            end
            StJal: begin
                // ALUOut already holds the target; this cycle's ALU makes OldPC + 4 for rd.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = StAluWb;
            end
            StLuiWb: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            default: begin
                state_valid = 1'b0;
                state_d     = StFetch;
            end
        endcase

        imm_src     = imm_src_dec;
        alu_control = alu_control_dec;

        if (reset || !state_valid) begin
            pc_write    = reset ? RESET_PC_WRITE : 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            imm_src     = 3'b000;
            reg_write   = 1'b0;
            retire      = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios followed by
// random instruction streams with random mid-instruction resets.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [18:0] dut_vec;

    int tests = 0;
    int fails = 0;

    multicycle_control #(
        .RESET_PC_WRITE (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .retire      (retire),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, alu_control, imm_src, reg_write, retire, illegal_op};

    function automatic logic [18:0] pack(input logic pcw, input logic adr, input logic mw,
                                         input logic irw, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [2:0] alu, input logic [2:0] imm,
                                         input logic rw, input logic ret, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret, ill};
    endfunction

    function automatic bit legal(input logic [6:0] o);
        return o == 7'h03 || o == 7'h23 || o == 7'h33 || o == 7'h13 ||
               o == 7'h63 || o == 7'h6f || o == 7'h37;
    endfunction

    function automatic int latency(input logic [6:0] o);
        case (o)
            7'h03:   return 5;
            7'h23:   return 4;
            7'h33:   return 4;
            7'h13:   return 4;
            7'h63:   return 3;
            7'h6f:   return 4;
            7'h37:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] o);
        case (o)
            7'h23:   return 3'd1;
            7'h63:   return 3'd2;
            7'h37:   return 3'd3;
            7'h6f:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7);
        case (f3)
            3'b000:  return (o == 7'h33 && f7) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs at cycle 'k' (0 = fetch cycle) of an instruction.
    function automatic logic [18:0] model(input int k, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z);
        logic [2:0] im;
        logic [2:0] fa;
        logic       br;
        im = imm_ref(o);
        fa = funct_alu(o, f3, f7);
        br = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        if (k == 0) return pack(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, im, 0, 0, 0);
        if (k == 1) return pack(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, im, 0, 0, !legal(o));
        case (o)
            7'h03: begin
                if (k == 2) return pack(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, im, 0, 0, 0);
                if (k == 3) return pack(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im, 0, 0, 0);
                return pack(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, im, 1, 1, 0);
            end
            7'h23: begin
                if (k == 2) return pack(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, im, 0, 0, 0);
                return pack(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, im, 0, 1, 0);
            end
            7'h33: begin
                if (k == 2) return pack(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, fa, im, 0, 0, 0);
                return pack(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im, 1, 1, 0);
            end
            7'h13: begin
                if (k == 2) return pack(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, fa, im, 0, 0, 0);
                return pack(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im, 1, 1, 0);
            end
            7'h63: return pack(br, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, im, 0, 1, 0);
            7'h6f: begin
                if (k == 2) return pack(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, im, 0, 0, 0);
                return pack(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im, 1, 1, 0);
            end
            7'h37: return pack(0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 3'd0, im, 1, 1, 0);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
        end
    endtask

    // Hold reset for 'cycles' rising edges starting now; outputs must stay all-zero.
    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b1;
        #1;
        check($sformatf("%s rst0", tag), dut_vec, '0);
        for (int r = 1; r <= cycles; r++) begin
            @(negedge clk);
            check($sformatf("%s rst%0d", tag, r), dut_vec, '0);
        end
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH. abort_at >= 0 asserts reset at that cycle.
    // zmode < 0 randomizes zero every cycle, otherwise holds it at zmode.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at, input int rst_cycles,
                             input string tag);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        for (int k = 0; k < latency(o); k++) begin
            if (k == abort_at) begin
                do_reset(rst_cycles, tag);
                return;
            end
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check($sformatf("%s op=%02h f3=%0d f7=%0d z=%0d cyc%0d", tag, o, f3, f7, zero, k),
                  dut_vec, model(k, o, f3, f7, zero));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] legal_ops [7];
        logic [6:0] ro;
        legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37};
        reset    = 1'b1;
        op       = 7'h23;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        @(negedge clk);
        do_reset(2, "init");

        // lw aborted in MEMREAD by a 3-cycle reset, then rerun in full.
        run_instr(7'h03, 3'b010, 1'b0, -1, 3, 3, "lw_abort");
        run_instr(7'h03, 3'b010, 1'b0, -1, -1, 0, "lw");
        run_instr(7'h23, 3'b010, 1'b0, -1, -1, 0, "sw");
        run_instr(7'h63, 3'b000, 1'b0, 1, -1, 0, "beq_taken");
        run_instr(7'h63, 3'b000, 1'b0, 0, -1, 0, "beq_not");
        run_instr(7'h63, 3'b001, 1'b0, 1, -1, 0, "bne_z1");
        run_instr(7'h63, 3'b001, 1'b0, 0, -1, 0, "bne_z0");
        run_instr(7'h63, 3'b100, 1'b0, 1, -1, 0, "blt_unsup");
        run_instr(7'h33, 3'b000, 1'b1, -1, -1, 0, "sub");
        run_instr(7'h13, 3'b000, 1'b1, -1, -1, 0, "addi_b30");
        run_instr(7'h33, 3'b111, 1'b0, -1, -1, 0, "and");
        run_instr(7'h13, 3'b110, 1'b0, -1, -1, 0, "ori");
        run_instr(7'h33, 3'b010, 1'b0, -1, -1, 0, "slt");
        run_instr(7'h6f, 3'b000, 1'b0, -1, -1, 0, "jal");
        run_instr(7'h37, 3'b000, 1'b0, -1, -1, 0, "lui");
        run_instr(7'h7f, 3'b000, 1'b0, -1, -1, 0, "illegal");
        run_instr(7'h33, 3'b000, 1'b0, -1, -1, 0, "after_ill");

        // Random instruction stream with occasional mid-instruction resets.
        for (int n = 0; n < 200; n++) begin
            int ab;
            if ($urandom_range(0, 7) == 0) begin
                do begin
                    ro = 7'($urandom);
                end while (legal(ro));
            end else begin
                ro = legal_ops[$urandom_range(0, 6)];
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ro, 3'($urandom), 1'($urandom), -1, ab, int'($urandom_range(1, 3)),
                      $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
